seq_mult_shift_add: RTL and testbench

- Sequential 8x8 unsigned shift-and-add multiplier producing a 16-bit product.
- Sits directly upstream and downstream of the team's 16-bit carry-lookahead adder. It drives the adder's A, B and carry-in, and registers the adder's Sum and Carry_out.
- The adder is instantiated by the parent and connected through the add_* ports. This block contains no adder logic.
- Operates under a start/busy/done handshake.

---
 rtl/seq_mult_shift_add_pkg.sv | 20 ++
 rtl/mult_step_ctr.sv | 57 +++++
 rtl/seq_mult_shift_add.sv | 131 +++++++++++++
 tb/tb_seq_mult_shift_add.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_shift_add_pkg.sv
// Shared constants for the shift-and-add multiplier and its adder test environment.
// State encodings are fixed so the adder bench can decode the FSM if it needs to.
package seq_mult_shift_add_pkg;

  localparam int unsigned DefaultN       = 8;
  localparam int unsigned DefaultAddWait = 1;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] ADD   = 2'b01;
  localparam logic [1:0] SHIFT = 2'b10;
  localparam logic [1:0] DONE  = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = IDLE,
    StAdd   = ADD,
    StShift = SHIFT,
    StDone  = DONE
  } state_t;

endpackage

// File: rtl/mult_step_ctr.sv
// Bit / adder-settle counter pair for the sequential multiplier.
// Strobes mark the last settle cycle of a step and the last bit of an operation.
module mult_step_ctr
  import seq_mult_shift_add_pkg::*;
#(
  parameter int unsigned N        = DefaultN,
  parameter int unsigned ADD_WAIT = DefaultAddWait
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic wait_step,
  input  logic bit_step,
  output logic wait_last,
  output logic bit_last
);

  localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned WW = (ADD_WAIT > 1) ? $clog2(ADD_WAIT) : 1;

  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;

  assign wait_last = (wait_cnt_q == WW'(ADD_WAIT - 1));
  assign bit_last  = (bit_cnt_q == BW'(N - 1));

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    wait_cnt_d = wait_cnt_q;
    if (clear) begin
      bit_cnt_d  = '0;
      wait_cnt_d = '0;
    end else begin
      // Stop at the terminal count so the counter never wraps past ADD_WAIT-1.
      if (wait_step && !wait_last) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
      if (bit_step) begin
        wait_cnt_d = '0;
        if (!bit_last) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/seq_mult_shift_add.sv
// Sequential NxN unsigned shift-and-add multiplier driving an external 2N-bit adder.
// Each bit: hold operands ADD_WAIT cycles, then capture the sum and shift.
module seq_mult_shift_add
  import seq_mult_shift_add_pkg::*;
#(
  parameter int unsigned N        = DefaultN,
  parameter int unsigned ADD_WAIT = DefaultAddWait
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic           ovf,
  output logic [2*N-1:0] add_a,
  output logic [2*N-1:0] add_b,
  output logic           add_cin,
  input  logic [2*N-1:0] add_sum,
  input  logic           add_cout
);

  state_t         state_q, state_d;
  logic [2*N-1:0] p_q, p_d;
  logic [2*N-1:0] m_q, m_d;
  logic [N-1:0]   q_q, q_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           ovf_q, ovf_d;

  logic ctr_clear, wait_step, bit_step;
  logic wait_last, bit_last;

  mult_step_ctr #(
    .N        (N),
    .ADD_WAIT (ADD_WAIT)
  ) u_step_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (ctr_clear),
    .wait_step (wait_step),
    .bit_step  (bit_step),
    .wait_last (wait_last),
    .bit_last  (bit_last)
  );

  assign add_a   = p_q;
  assign add_b   = q_q[0] ? m_q : '0;
  assign add_cin = 1'b0;
  assign product = p_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ovf     = ovf_q;

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    m_d       = m_q;
    q_d       = q_q;
    busy_d    = busy_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    ctr_clear = 1'b0;
    wait_step = 1'b0;
    bit_step  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          p_d       = '0;
          m_d       = {{N{1'b0}}, mcand};
          q_d       = mplier;
          ovf_d     = 1'b0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          ctr_clear = 1'b1;
          state_d   = StAdd;
        end
      end
      StAdd: begin
        wait_step = 1'b1;
        if (wait_last) begin
          state_d = StShift;
        end
      end
      StShift: begin
        p_d      = add_sum;
        // A carry out of 2N bits cannot happen legitimately; latch it as a fault.
        ovf_d    = ovf_q | add_cout;
        m_d      = m_q << 1;
        q_d      = q_q >> 1;
        bit_step = 1'b1;
        if (bit_last) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          state_d = StAdd;
        end
      end
      StDone: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      p_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      m_q     <= m_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Scoreboard bench for seq_mult_shift_add: default instance plus an ADD_WAIT=3 instance,
// each wired to a behavioural 16-bit adder.
module tb_seq_mult_shift_add;

  typedef struct {
    logic [15:0] prod;
    logic        ovf;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic fault = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start0 = 1'b0, start1 = 1'b0;
  logic [7:0]  mcand0 = '0, mplier0 = '0, mcand1 = '0, mplier1 = '0;
  logic        busy0, done0, ovf0, add_cin0, add_cout0, cout_m0;
  logic        busy1, done1, ovf1, add_cin1, add_cout1;
  logic [15:0] product0, add_a0, add_b0, add_sum0;
  logic [15:0] product1, add_a1, add_b1, add_sum1;

  assign {cout_m0, add_sum0}   = {1'b0, add_a0} + {1'b0, add_b0} + {16'd0, add_cin0};
  assign add_cout0             = cout_m0 | fault;
  assign {add_cout1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + {16'd0, add_cin1};

  seq_mult_shift_add u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start0),
    .mcand    (mcand0),
    .mplier   (mplier0),
    .busy     (busy0),
    .done     (done0),
    .product  (product0),
    .ovf      (ovf0),
    .add_a    (add_a0),
    .add_b    (add_b0),
    .add_cin  (add_cin0),
    .add_sum  (add_sum0),
    .add_cout (add_cout0)
  );

  seq_mult_shift_add #(
    .N        (8),
    .ADD_WAIT (3)
  ) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start1),
    .mcand    (mcand1),
    .mplier   (mplier1),
    .busy     (busy1),
    .done     (done1),
    .product  (product1),
    .ovf      (ovf1),
    .add_a    (add_a1),
    .add_b    (add_b1),
    .add_cin  (add_cin1),
    .add_sum  (add_sum1),
    .add_cout (add_cout1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns at the negedge of the accept cycle; acc is the edge count at acceptance.
  task automatic issue(input int which, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] p, input logic ov, input bit track,
                       output int acc);
    exp_t e;
    @(negedge clk);
    if (which == 0) begin
      start0 = 1'b1; mcand0 = a; mplier0 = b;
    end else begin
      start1 = 1'b1; mcand1 = a; mplier1 = b;
    end
    @(posedge clk);
    #1;
    acc    = cyc;
    e.prod = p;
    e.ovf  = ov;
    e.acc  = acc;
    e.lat  = (which == 0) ? 16 : 32;
    if (track) begin
      if (which == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic mult(input int which, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] p, input logic ov);
    int acc;
    issue(which, a, b, p, ov, 1'b1, acc);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      if (q0.size() == 0 && q1.size() == 0 && !busy0 && !busy1) break;
      @(negedge clk);
    end
    chk("drain_timeout_pending", q0.size() + q1.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_done(input int which, input logic [15:0] prod, input logic ov,
                            input logic bsy);
    exp_t e;
    if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done dut%0d: got product 0x%0h with no pending op", which, prod);
    end else begin
      e = (which == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("product dut%0d", which), {16'd0, prod}, {16'd0, e.prod});
      chk($sformatf("ovf dut%0d", which), {31'd0, ov}, {31'd0, e.ovf});
      chk($sformatf("latency dut%0d", which), cyc - e.acc, e.lat);
      chk($sformatf("busy_at_done dut%0d", which), {31'd0, bsy}, 32'd1);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (done0) begin
        check_done(0, product0, ovf0, busy0);
        @(negedge clk);
        chk("done_width dut0", {31'd0, done0}, 32'd0);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (done1) begin
        check_done(1, product1, ovf1, busy1);
        @(negedge clk);
        chk("done_width dut1", {31'd0, done1}, 32'd0);
      end
    end
  end

  initial begin
    int acc;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst busy", {31'd0, busy0}, 0);
    chk("rst done", {31'd0, done0}, 0);
    chk("rst ovf", {31'd0, ovf0}, 0);
    chk("rst product", {16'd0, product0}, 0);
    chk("rst add_a", {16'd0, add_a0}, 0);
    chk("rst add_b", {16'd0, add_b0}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    mult(0, 8'd13, 8'd11, 16'h008F, 1'b0);   wait_drain();
    mult(0, 8'd255, 8'd255, 16'hFE01, 1'b0); wait_drain();
    mult(0, 8'h02, 8'h00, 16'h0000, 1'b0);   wait_drain();
    mult(0, 8'h00, 8'hFF, 16'h0000, 1'b0);   wait_drain();
    mult(0, 8'd170, 8'd85, 16'h3872, 1'b0);  wait_drain();
    mult(0, 8'd1, 8'd255, 16'h00FF, 1'b0);   wait_drain();
    mult(0, 8'd128, 8'd2, 16'h0100, 1'b0);   wait_drain();

    // Starts during ADD and during DONE must both be ignored.
    issue(0, 8'd7, 8'd9, 16'h003F, 1'b0, 1'b1, acc);
    repeat (4) @(negedge clk);
    start0 = 1'b1; mcand0 = 8'd2; mplier0 = 8'd2;
    @(negedge clk);
    start0 = 1'b0;
    while (cyc < acc + 16) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_drain();
    repeat (40) @(negedge clk);
    chk("busy_after_ignored_start", {31'd0, busy0}, 0);

    mult(1, 8'd200, 8'd100, 16'h4E20, 1'b0); wait_drain();

    // Force carry-out during exactly the first SHIFT cycle.
    issue(0, 8'd5, 8'd6, 16'h001E, 1'b1, 1'b1, acc);
    chk("ovf_clear_at_start", {31'd0, ovf0}, 0);
    @(negedge clk);
    fault = 1'b1;
    @(negedge clk);
    fault = 1'b0;
    chk("ovf_sticky_mid", {31'd0, ovf0}, 1);
    wait_drain();
    chk("ovf_held_idle", {31'd0, ovf0}, 1);
    mult(0, 8'd1, 8'd1, 16'h0001, 1'b0);     wait_drain();

    // Asynchronous reset mid-operation discards the partial result.
    issue(0, 8'd13, 8'd11, 16'h0000, 1'b0, 1'b0, acc);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", {31'd0, busy0}, 0);
    chk("midrst done", {31'd0, done0}, 0);
    chk("midrst ovf", {31'd0, ovf0}, 0);
    chk("midrst product", {16'd0, product0}, 0);
    chk("midrst add_a", {16'd0, add_a0}, 0);
    chk("midrst add_b", {16'd0, add_b0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mult(0, 8'd3, 8'd4, 16'h000C, 1'b0);     wait_drain();
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
